// File: rtl/adsr_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : adsr_envelope
//  Function : Gated ADSR envelope; scales an unsigned 8-bit oscillator sample
//             about midscale by the current envelope level.
//  Revision : 1.0
// ============================================================================
module adsr_envelope #(
    parameter int BASE_SPEED = 50000000,
    parameter int TICK_HZ    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic [7:0] sample_in,
    input  logic [7:0] attack,
    input  logic [7:0] decay,
    input  logic [7:0] sustain,
    input  logic [7:0] release_rate,
    output logic [7:0] out,
    output logic [7:0] level,
    output logic [2:0] state,
    output logic       active
);

    localparam int            DIV     = BASE_SPEED / TICK_HZ;
    localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    level_q, level_d;
    logic [7:0]    out_q, out_d;
    logic          gate_q, gate_d;

    logic               tick;
    logic               rise;
    logic [7:0]         rate;
    logic               cnt_hit;
    logic signed [8:0]  samp_s;
    logic signed [17:0] prod;
    logic               unused_prod_bits;

    assign tick = (pre_q == PRE_MAX);
    assign rise = gate & ~gate_q;

    always_comb begin
        case (state_q)
            ST_ATTACK: rate = attack;
            ST_DECAY:  rate = decay;
            default:   rate = release_rate;
        endcase
    end
    assign cnt_hit = (cnt_q == rate);

    // Signed product of (sample - 128) and level; bits [15:8] are floor(p/256).
    assign samp_s           = $signed({1'b0, sample_in}) - 9'sd128;
    assign prod             = samp_s * $signed({1'b0, level_q});
    assign unused_prod_bits = ^{prod[17:16], prod[7:0]};

    always_comb begin
        pre_d   = tick ? '0 : pre_q + PW'(1);
        gate_d  = gate;
        out_d   = prod[15:8] + 8'd128;
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;

        if (rise) begin
            state_d = ST_ATTACK;
            cnt_d   = '0;
        end else if (!gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                               state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: level_d = '0;
                ST_ATTACK: begin
                    if (tick) begin
                        if (level_q == 8'hFF) begin
                            state_d = ST_DECAY;
                            cnt_d   = '0;
                        end else if (cnt_hit) begin
                            level_d = level_q + 8'd1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_DECAY: begin
                    if (tick) begin
                        if (level_q <= sustain) begin
                            state_d = ST_SUSTAIN;
                            level_d = sustain;
                        end else if (cnt_hit) begin
                            level_d = level_q - 8'd1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_SUSTAIN: level_d = sustain;
                ST_RELEASE: begin
                    if (tick) begin
                        if (level_q == 8'd0) begin
                            state_d = ST_IDLE;
                        end else if (cnt_hit) begin
                            level_d = level_q - 8'd1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            out_q   <= 8'd128;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            out_q   <= out_d;
            gate_q  <= gate_d;
        end
    end

    assign out    = out_q;
    assign level  = level_q;
    assign state  = state_q;
    assign active = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adsr_envelope
//  Function : Directed self-checking bench for adsr_envelope (DIV = 10).
//  Revision : 1.0
// ============================================================================
module tb_adsr_envelope;

    logic       clk = 1'b0;
    logic       rst;
    logic       gate;
    logic [7:0] sample_in;
    logic [7:0] attack;
    logic [7:0] decay;
    logic [7:0] sustain;
    logic [7:0] release_rate;
    logic [7:0] out;
    logic [7:0] level;
    logic [2:0] state;
    logic       active;

    int n_checks = 0;
    int n_errors = 0;
    int c;

    adsr_envelope #(
        .BASE_SPEED (100),
        .TICK_HZ    (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gate         (gate),
        .sample_in    (sample_in),
        .attack       (attack),
        .decay        (decay),
        .sustain      (sustain),
        .release_rate (release_rate),
        .out          (out),
        .level        (level),
        .state        (state),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input int v, input int bound, output int cyc);
        cyc = 0;
        while (int'(level) != v && cyc < bound) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic wait_state(input int v, input int bound, output int cyc);
        cyc = 0;
        while (int'(state) != v && cyc < bound) begin
            step(1);
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; gate = 1'b1; sample_in = 8'd255;
        attack = 8'd0; decay = 8'd0; sustain = 8'd200; release_rate = 8'd0;
        step(3);
        check("rst_out", out, 128);
        check("rst_level", level, 0);
        check("rst_state", state, 0);
        check("rst_active", active, 0);

        rst = 1'b0;
        step(1);
        check("rise_after_rst", state, 1);
        check("active_attack", active, 1);

        // Full envelope with unit rates: one step per tick.
        wait_level(255, 2700, c);
        check("attack_peak", level, 255);
        check("attack_time_ok", int'((c + 1) >= 2540 && (c + 1) <= 2560), 1);
        wait_state(2, 20, c);
        check("decay_entry", state, 2);
        check("decay_entry_time", c, 10);
        wait_level(200, 700, c);
        check("decay_reach", level, 200);
        check("decay_time", c, 550);
        step(9);
        check("decay_hold", state, 2);
        step(1);
        check("sustain_entry", state, 3);
        check("sustain_level", level, 200);
        sustain = 8'd150;
        step(1);
        check("sustain_track", level, 150);
        sustain = 8'd200;
        step(1);
        gate = 1'b0;
        step(1);
        check("release_entry", state, 4);
        wait_state(0, 2200, c);
        check("idle_reached", state, 0);
        check("idle_level", level, 0);
        check("idle_active", active, 0);
        check("release_time_ok", int'(c >= 2000 && c <= 2015), 1);

        // Scaling arithmetic.
        sample_in = 8'd123;
        step(1);
        check("scale_lvl0", out, 128);
        gate = 1'b1;
        wait_level(128, 1500, c);
        check("reach_128", level, 128);
        sample_in = 8'd200;
        step(1);
        check("scale_200_128", out, 164);
        sample_in = 8'd50;
        step(1);
        check("scale_50_128", out, 89);
        wait_level(255, 1500, c);
        check("reach_255", level, 255);
        sample_in = 8'd0;
        step(1);
        check("scale_0_255", out, 0);
        sample_in = 8'd255;
        step(1);
        check("scale_255_255", out, 254);

        // Gate falls on the very tick that would move DECAY into SUSTAIN.
        sustain = 8'd250;
        wait_level(250, 200, c);
        check("coll_decay_250", level, 250);
        step(9);
        check("coll_pre_state", state, 2);
        gate = 1'b0;
        step(1);
        check("coll_fall_release", state, 4);

        // Rise on a tick cycle: the tick's decrement is discarded.
        wait_level(240, 200, c);
        check("coll_rel_240", level, 240);
        step(9);
        gate = 1'b1;
        step(1);
        check("coll_rise_state", state, 1);
        check("coll_rise_level", level, 240);
        step(10);
        check("coll_rise_next", level, 241);

        // Retrigger from RELEASE at 90 with a part-counted release rate.
        gate = 1'b0;
        release_rate = 8'd2;
        step(1);
        check("retrig_release", state, 4);
        wait_level(90, 5000, c);
        check("retrig_reach_90", level, 90);
        step(12);
        gate = 1'b1;
        attack = 8'd3;
        step(1);
        check("retrig_state", state, 1);
        check("retrig_level", level, 90);
        step(36);
        check("retrig_hold", level, 90);
        step(1);
        check("retrig_step", level, 91);

        // Reset mid-note, then attack rate 3 from a clean start.
        rst = 1'b1;
        step(1);
        check("midrst_state", state, 0);
        check("midrst_level", level, 0);
        check("midrst_out", out, 128);
        check("midrst_active", active, 0);
        step(2);
        rst = 1'b0;
        step(1);
        check("rate_start", state, 1);
        step(38);
        check("rate_t39", level, 0);
        step(1);
        check("rate_t40", level, 1);
        step(39);
        check("rate_t79", level, 1);
        step(1);
        check("rate_t80", level, 2);
        step(319);
        check("rate_t399", level, 9);
        step(1);
        check("rate_t400", level, 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adsr_envelope.md
# adsr_envelope

Gated ADSR amplitude-envelope stage that sits directly downstream of the noise/sawtooth oscillators. It takes their unsigned 8-bit sample stream and scales it about midscale (128) by an 8-bit envelope level. The level runs through attack, decay, sustain and release phases, clocked by a slow tick derived from the system clock. The output feeds the mixer/DAC path in place of the raw oscillator sample.

## Interface
- `BASE_SPEED`, default 50000000: system clock frequency in Hz.
- `TICK_HZ`, default 1000: envelope tick rate in Hz. `DIV = BASE_SPEED / TICK_HZ` (integer division); `DIV` must be ≥ 1.
- `clk` input, 1 bit: system clock. One clock domain only.
- `rst` input, 1 bit: synchronous, active-high reset.
- `gate` input, 1 bit: note on (1) / note off (0).
- `sample_in` input, 8 bits: unsigned oscillator sample, midscale 128.
- `attack` input, 8 bits: attack rate; the level steps +1 every `attack+1` ticks.
- `decay` input, 8 bits: decay rate; the level steps −1 every `decay+1` ticks.
- `sustain` input, 8 bits: sustain level, 0..255.
- `release` input, 8 bits: release rate; the level steps −1 every `release+1` ticks.
- `out` output, 8 bits: enveloped unsigned sample. Registered.
- `level` output, 8 bits: current envelope level. Registered.
- `state` output, 3 bits: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `active` output, 1 bit: 1 whenever `state` ≠ IDLE.

## Operation
- **Prescaler:** counts 0..DIV−1 and wraps. `tick` is 1 in the cycle where the count equals DIV−1. With DIV=1, `tick` is 1 every cycle.
- **Rate counter:** 8-bit `cnt`. On a tick in a stepping state:
  - if `cnt` equals the active rate input: step the level and clear `cnt`;
  - otherwise: increment `cnt`.
- **Gate edge:** `gate_q` is a registered copy of `gate`, and `rise = gate & ~gate_q`. `gate_q` resets to 0, so a gate held high through reset produces a rise in the first cycle after reset.
- **Priority per cycle**, evaluated every clock, not only on ticks:
  1. `rise`: go to ATTACK, clear `cnt`, keep the current level (no restart from 0).
  2. `gate`=0 while in ATTACK, DECAY or SUSTAIN: go to RELEASE, clear `cnt`.
  3. Tick-driven stage behaviour below.
- **IDLE:** level = 0.
- **ATTACK, on tick:**
  - level = 255: go to DECAY, clear `cnt`;
  - otherwise: rate-counter step +1 using `attack`.
- **DECAY, on tick:**
  - level ≤ `sustain`: go to SUSTAIN, set level = `sustain`;
  - otherwise: rate-counter step −1 using `decay`.
- **SUSTAIN:** level = `sustain` every cycle, tracking live changes to the input.
- **RELEASE, on tick:**
  - level = 0: go to IDLE;
  - otherwise: rate-counter step −1 using `release`.
- **Level saturation:** the level never wraps; it stays clamped to 0..255.
- **Scaling:**
  - s = `sample_in` − 128, 9-bit signed, range −128..127.
  - p = s × level, 17-bit signed.
  - `out` = 128 + (p >>> 8), arithmetic shift (floor).
  - Result is always within 0..254, so no clipping logic is needed.
- **Simultaneous events:**
  - gate fall in the same cycle as DECAY→SUSTAIN: RELEASE wins.
  - rise in the same cycle as a tick: ATTACK entry wins; the tick's step is discarded.
- **Reset mid-note:** the next cycle shows IDLE with level 0 and `out` 128, regardless of the prior state.

## Timing
- Reset values:
  - `out` = 128, `level` = 0, `state` = IDLE, `active` = 0;
  - prescaler = 0, `cnt` = 0, `gate_q` = 0.
- Gate response latency:
  - `state` changes in the cycle after `gate` changes (one registered stage);
  - `active` follows `state` combinationally from the state register.
- `out(t+1)` = f(`sample_in(t)`, `level(t)`): one-cycle latency from a sample to its scaled output.
- Level updates:
  - level changes take effect the cycle after the tick;
  - the first step after a state entry occurs `rate+1` ticks after entry.
- Rate inputs are sampled on each tick. Changing a rate mid-stage takes effect at the next compare, with no reset of `cnt`.

## Test plan
Benches use `BASE_SPEED`=100, `TICK_HZ`=10, giving DIV=10.
- **Reset:** assert `rst` with `gate`=1 and `sample_in`=255 → `out`=128, `level`=0, `state`=0, `active`=0. The cycle after release of `rst` → `state`=1.
- **Full envelope:** `attack`=0, `decay`=0, `sustain`=200, `release`=0, `gate` high:
  - `level` reaches 255 after 255 ticks (2550 cycles ±10);
  - DECAY reaches level 200 after 55 more ticks, then SUSTAIN on the next tick;
  - `gate` low → RELEASE, level 0, then IDLE after 201 ticks.
- **Rate scaling:** `attack`=3 → the level increments exactly every 4 ticks (40 cycles); `level` = 10 after 40 ticks.
- **Scaling arithmetic:**

  | `sample_in` | `level` | `out` |
  |---|---|---|
  | 0 | 255 | 0 |
  | 255 | 255 | 254 |
  | 200 | 128 | 164 |
  | 50 | 128 | 89 |
  | any | 0 | 128 |

- **Retrigger:** in RELEASE at level 90, pulse `gate` high → ATTACK resumes from 90, not 0, and `cnt` is cleared.
- **Collisions:**
  - gate fall on the same cycle DECAY hits `sustain` → next `state`=4;
  - `rise` on a tick cycle → ATTACK with the level unchanged.
